wca_lime_iq_port: RTL and testbench

WCA_LIME_IQ_PORT -- requirements
Module: wca_lime_iq_port

---
 rtl/wca_lime_iq_port.sv | 157 +++++++++++++++
 tb/tb_wca_lime_iq_port.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wca_lime_iq_port.sv
// Interleaved I/Q port: RX word-pair assembly with DC removal and test patterns,
// plus a TX pair FIFO serialised onto an alternating I/Q word bus.
module wca_lime_iq_port #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned FIFO_LOG2 = 2,
  parameter int unsigned DC_SHIFT  = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_aclr,
  input  logic [7:0]           i_ctrl,
  input  logic                 i_rx_iqsel,
  input  logic [WIDTH-1:0]     i_rx_data,
  output logic [2*WIDTH-1:0]   o_rx_iq,
  output logic                 o_rx_strobe,
  input  logic [2*WIDTH-1:0]   i_tx_iq,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_iqsel,
  output logic [WIDTH-1:0]     o_tx_data,
  output logic                 o_tx_underflow,
  output logic [2*WIDTH-1:0]   o_rx_dc
);
  localparam int unsigned        DEPTH    = 2 ** FIFO_LOG2;
  localparam int unsigned        AW       = WIDTH + DC_SHIFT;
  localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [WIDTH-1:0]   PAT_POS  = WIDTH'(256);
  localparam logic [WIDTH-1:0]   PAT_NEG  = WIDTH'(-256);

  // acc + x - (acc >>> DC_SHIFT), all in two's complement modulo 2**AW
  function automatic logic [AW-1:0] f_acc_next(input logic [AW-1:0] acc,
                                               input logic [WIDTH-1:0] x);
    logic [AW-1:0] x_ext;
    logic [AW-1:0] est_ext;
    x_ext   = {{DC_SHIFT{x[WIDTH-1]}}, x};
    est_ext = {{DC_SHIFT{acc[AW-1]}}, acc[AW-1:DC_SHIFT]};
    return acc + x_ext - est_ext;
  endfunction

  function automatic logic [WIDTH-1:0] f_sub_sat(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (d[WIDTH] != d[WIDTH-1]) return {d[WIDTH], {(WIDTH-1){~d[WIDTH]}}};
    return d[WIDTH-1:0];
  endfunction

  // RX side
  logic [AW-1:0]      r_acc_i, r_acc_q;
  logic [WIDTH-1:0]   w_est_i, w_est_q;
  logic               r_have_i;
  logic [WIDTH-1:0]   r_i_raw, r_i_corr, r_ramp;
  logic [2*WIDTH-1:0] r_rx_iq, w_pair;
  logic               r_rx_strobe;
  logic               w_i_take, w_pair_done;

  // TX side
  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wptr, r_rptr;
  logic [FIFO_LOG2:0] r_count;
  logic [2*WIDTH-1:0] r_hold, w_hold_nx;
  logic               r_tx_iqsel, r_underflow;
  logic [WIDTH-1:0]   r_tx_data, w_tx_data_nx;
  logic               w_empty, w_push, w_pop, w_pop_ok, w_iqsel_nx;
  logic               w_unused_ctrl5;

  assign w_unused_ctrl5 = i_ctrl[5];

  assign w_est_i     = r_acc_i[AW-1:DC_SHIFT];
  assign w_est_q     = r_acc_q[AW-1:DC_SHIFT];
  assign w_i_take    = i_ctrl[6] & i_rx_iqsel;
  assign w_pair_done = i_ctrl[6] & ~i_rx_iqsel & r_have_i;

  always_comb begin
    w_pair = r_hold;
    unique case (i_ctrl[1:0])
      2'd0: w_pair = r_hold;
      2'd1: w_pair = {f_sub_sat(i_rx_data, w_est_q), r_i_corr};
      2'd2: w_pair = {i_rx_data, r_i_raw};
      2'd3: w_pair = i_ctrl[4] ? {~r_ramp, r_ramp} : {PAT_NEG, PAT_POS};
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_acc_i <= '0; r_acc_q <= '0; r_have_i <= 1'b0; r_i_raw <= '0;
      r_i_corr <= '0; r_ramp <= '0; r_rx_iq <= '0; r_rx_strobe <= 1'b0;
    end else if (i_aclr) begin
      r_acc_i <= '0; r_acc_q <= '0; r_have_i <= 1'b0; r_i_raw <= '0;
      r_i_corr <= '0; r_ramp <= '0; r_rx_iq <= '0; r_rx_strobe <= 1'b0;
    end else begin
      r_rx_strobe <= w_pair_done;
      if (w_i_take) begin
        r_have_i <= 1'b1;
        r_i_raw  <= i_rx_data;
        r_i_corr <= f_sub_sat(i_rx_data, w_est_i);
        r_acc_i  <= f_acc_next(r_acc_i, i_rx_data);
      end
      if (w_pair_done) begin
        r_have_i <= 1'b0;
        r_rx_iq  <= w_pair;
        r_acc_q  <= f_acc_next(r_acc_q, i_rx_data);
        if (i_ctrl[1:0] == 2'd3 && i_ctrl[4]) r_ramp <= r_ramp + 1'b1;
      end
    end
  end

  assign w_empty    = (r_count == '0);
  assign o_tx_ready = (r_count != CNT_FULL);
  assign w_push     = i_tx_valid & o_tx_ready;
  // A pop happens on every enabled edge where the bus is about to carry I.
  assign w_pop      = i_ctrl[7] & ~r_tx_iqsel;
  assign w_pop_ok   = w_pop & ~w_empty;
  assign w_iqsel_nx = w_pop;
  assign w_hold_nx  = w_pop ? (w_empty ? '0 : r_mem[r_rptr]) : r_hold;

  always_comb begin
    w_tx_data_nx = '0;
    unique case (i_ctrl[3:2])
      2'd0: w_tx_data_nx = i_rx_data;
      2'd1: w_tx_data_nx = w_iqsel_nx ? w_hold_nx[WIDTH-1:0] : w_hold_nx[2*WIDTH-1:WIDTH];
      2'd2: w_tx_data_nx = w_iqsel_nx ? PAT_POS : PAT_NEG;
      2'd3: w_tx_data_nx = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_tx_iq;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_hold <= '0;
      r_tx_iqsel <= 1'b0; r_tx_data <= '0; r_underflow <= 1'b0;
    end else if (i_aclr) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_hold <= '0;
      r_tx_iqsel <= 1'b0; r_tx_data <= '0; r_underflow <= 1'b0;
    end else begin
      r_tx_iqsel <= w_iqsel_nx;
      r_tx_data  <= w_tx_data_nx;
      r_hold     <= w_hold_nx;
      if (w_pop && w_empty) r_underflow <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop_ok) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  assign o_rx_iq        = r_rx_iq;
  assign o_rx_strobe    = r_rx_strobe;
  assign o_tx_iqsel     = r_tx_iqsel;
  assign o_tx_data      = r_tx_data;
  assign o_tx_underflow = r_underflow;
  assign o_rx_dc        = {w_est_q, w_est_i};

endmodule

// File: tb/tb_wca_lime_iq_port.sv
// Bench for wca_lime_iq_port: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_wca_lime_iq_port;
  localparam int W = 12;
  localparam int S = 10;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           aclr = 1'b0;
  logic [7:0]     ctrl = '0;
  logic           rx_iqsel = 1'b0;
  logic [W-1:0]   rx_data = '0;
  logic [2*W-1:0] tx_iq = '0;
  logic           tx_valid = 1'b0;
  logic [2*W-1:0] o_rx_iq, o_rx_dc;
  logic           o_rx_strobe, o_tx_ready, o_tx_iqsel, o_tx_underflow;
  logic [W-1:0]   o_tx_data;

  int checks = 0;
  int errors = 0;

  wca_lime_iq_port #(.WIDTH(W), .FIFO_LOG2(2), .DC_SHIFT(S)) dut (
    .i_clock(clk), .i_reset(rst), .i_aclr(aclr), .i_ctrl(ctrl),
    .i_rx_iqsel(rx_iqsel), .i_rx_data(rx_data), .o_rx_iq(o_rx_iq),
    .o_rx_strobe(o_rx_strobe), .i_tx_iq(tx_iq), .i_tx_valid(tx_valid),
    .o_tx_ready(o_tx_ready), .o_tx_iqsel(o_tx_iqsel), .o_tx_data(o_tx_data),
    .o_tx_underflow(o_tx_underflow), .o_rx_dc(o_rx_dc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int est(input longint acc);
    return int'(acc >>> S);
  endfunction

  function automatic logic [2*W-1:0] pack(input int q, input int i);
    return {q[W-1:0], i[W-1:0]};
  endfunction

  // Behavioural model
  longint m_acc_i, m_acc_q;
  bit     m_have_i, m_strobe, m_iqsel, m_uf;
  int     m_i_raw, m_i_corr, m_ramp, m_rx_i, m_rx_q, m_hold_i, m_hold_q, m_tx_data;
  int     m_fifo_i[$];
  int     m_fifo_q[$];

  task automatic model_clear();
    m_acc_i = 0; m_acc_q = 0; m_have_i = 0; m_strobe = 0; m_iqsel = 0; m_uf = 0;
    m_i_raw = 0; m_i_corr = 0; m_ramp = 0; m_rx_i = 0; m_rx_q = 0;
    m_hold_i = 0; m_hold_q = 0; m_tx_data = 0;
    m_fifo_i.delete(); m_fifo_q.delete();
  endtask

  task automatic model_step();
    int x;
    bit rdy;
    x = sx(rx_data);
    rdy = m_fifo_i.size() < D;
    m_strobe = 0;
    if (ctrl[6] && rx_iqsel) begin
      m_i_raw  = x;
      m_i_corr = sat(x - est(m_acc_i));
      m_acc_i  = m_acc_i + x - est(m_acc_i);
      m_have_i = 1;
    end else if (ctrl[6] && !rx_iqsel && m_have_i) begin
      m_have_i = 0;
      m_strobe = 1;
      case (ctrl[1:0])
        2'd0: begin m_rx_i = m_hold_i; m_rx_q = m_hold_q; end
        2'd1: begin m_rx_i = m_i_corr; m_rx_q = sat(x - est(m_acc_q)); end
        2'd2: begin m_rx_i = m_i_raw; m_rx_q = x; end
        default: begin
          if (ctrl[4]) begin
            m_rx_i = m_ramp; m_rx_q = ~m_ramp; m_ramp = (m_ramp + 1) % 4096;
          end else begin
            m_rx_i = 256; m_rx_q = -256;
          end
        end
      endcase
      m_acc_q = m_acc_q + x - est(m_acc_q);
    end
    if (ctrl[7] && !m_iqsel) begin
      if (m_fifo_i.size() == 0) begin
        m_hold_i = 0; m_hold_q = 0; m_uf = 1;
      end else begin
        m_hold_i = m_fifo_i.pop_front(); m_hold_q = m_fifo_q.pop_front();
      end
    end
    if (tx_valid && rdy) begin
      m_fifo_i.push_back(sx(tx_iq[W-1:0]));
      m_fifo_q.push_back(sx(tx_iq[2*W-1:W]));
    end
    m_iqsel = ctrl[7] ? !m_iqsel : 1'b0;
    case (ctrl[3:2])
      2'd0: m_tx_data = x;
      2'd1: m_tx_data = m_iqsel ? m_hold_i : m_hold_q;
      2'd2: m_tx_data = m_iqsel ? 256 : -256;
      default: m_tx_data = 0;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || aclr) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("m_rx_iq", o_rx_iq, pack(m_rx_q, m_rx_i));
      check("m_rx_strobe", o_rx_strobe, m_strobe);
      check("m_rx_dc", o_rx_dc, pack(est(m_acc_q), est(m_acc_i)));
      check("m_tx_ready", o_tx_ready, m_fifo_i.size() < D);
      check("m_tx_iqsel", o_tx_iqsel, m_iqsel);
      check("m_tx_data", o_tx_data, m_tx_data[W-1:0]);
      check("m_tx_uf", o_tx_underflow, m_uf);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_aclr();
    aclr = 1'b1; tick(); aclr = 1'b0;
  endtask

  task automatic rx_pair(input logic [W-1:0] i_w, input logic [W-1:0] q_w);
    rx_iqsel = 1'b1; rx_data = i_w; tick();
    rx_iqsel = 1'b0; rx_data = q_w; tick();
  endtask

  initial begin
    logic [W-1:0] k12;
    repeat (3) tick();
    check("rst_rx_iq", o_rx_iq, 0);
    check("rst_strobe", o_rx_strobe, 0);
    check("rst_ready", o_tx_ready, 1);
    check("rst_iqsel", o_tx_iqsel, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_uf", o_tx_underflow, 0);
    check("rst_dc", o_rx_dc, 0);
    rst = 1'b0;

    // Raw pair assembly
    ctrl = 8'h42;
    rx_iqsel = 1'b1; rx_data = 12'h123; tick();
    check("raw_no_strobe_on_i", o_rx_strobe, 0);
    rx_iqsel = 1'b0; rx_data = 12'hF00; tick();
    check("raw_pair", o_rx_iq, 24'hF00123);
    check("raw_strobe", o_rx_strobe, 1);
    rx_data = 12'h055; tick();
    check("raw_single_strobe", o_rx_strobe, 0);
    check("raw_orphan_q_kept", o_rx_iq, 24'hF00123);

    ctrl = 8'h43;
    rx_pair(12'h3A5, 12'h111);
    check("fixed_pattern", o_rx_iq, 24'hF00100);

    // FIFO fill, drain, underflow
    do_aclr();
    ctrl = 8'h04;
    for (int k = 0; k < 5; k++) begin
      tx_iq = {12'(12'h200 + k), 12'(12'h100 + k)}; tx_valid = 1'b1; tick();
    end
    tx_valid = 1'b0;
    check("fifo_full_ready", o_tx_ready, 0);
    ctrl = 8'h84;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_i", o_tx_data, 12'(12'h100 + k));
      check("drain_iqsel1", o_tx_iqsel, 1);
      tick();
      check("drain_q", o_tx_data, 12'(12'h200 + k));
      check("drain_iqsel0", o_tx_iqsel, 0);
    end
    check("uf_clear_before", o_tx_underflow, 0);
    tick();
    check("uf_data", o_tx_data, 0);
    check("uf_set", o_tx_underflow, 1);
    check("uf_ready", o_tx_ready, 1);

    // Ramp with wrap
    do_aclr();
    ctrl = 8'h53;
    for (int k = 0; k < 2050; k++) begin
      rx_pair(12'($urandom), 12'($urandom));
      k12 = 12'(k);
      check("ramp", o_rx_iq, {~k12, k12});
      if (k == 2047) check("ramp_7ff", o_rx_iq[W-1:0], 12'h7FF);
      if (k == 2048) check("ramp_800", o_rx_iq[W-1:0], 12'h800);
    end

    // Async reset mid-pair
    do_aclr();
    ctrl = 8'hCA;
    rx_pair(12'h456, 12'h789);
    rx_iqsel = 1'b1; rx_data = 12'h321; tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rx_iq", o_rx_iq, 0);
    check("arst_strobe", o_rx_strobe, 0);
    check("arst_tx_data", o_tx_data, 0);
    check("arst_iqsel", o_tx_iqsel, 0);
    check("arst_ready", o_tx_ready, 1);
    rst = 1'b0;
    rx_iqsel = 1'b0; rx_data = 12'h0AB; tick();
    check("arst_no_strobe", o_rx_strobe, 0);
    check("arst_rx_iq_after", o_rx_iq, 0);

    // DC convergence
    do_aclr();
    ctrl = 8'h41;
    for (int k = 0; k < 8 * (1 << S); k++) rx_pair(12'd100, 12'hFCE);
    check_near("dc_i", sx(o_rx_dc[W-1:0]), 100, 1);
    check_near("dc_q", sx(o_rx_dc[2*W-1:W]), -50, 1);
    check_near("dc_out_i", sx(o_rx_iq[W-1:0]), 0, 1);
    check_near("dc_out_q", sx(o_rx_iq[2*W-1:W]), 0, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        ctrl = 8'($urandom);
        if ($urandom_range(0, 3) != 0) ctrl[6] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) rx_iqsel = 1'($urandom_range(0, 1));
      else rx_iqsel = ~rx_iqsel;
      case ($urandom_range(0, 5))
        0: rx_data = 12'h7FF;
        1: rx_data = 12'h800;
        default: rx_data = 12'($urandom);
      endcase
      tx_valid = 1'($urandom_range(0, 1));
      tx_iq = 24'($urandom);
      aclr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end
    aclr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
